// File: rtl/ws_tile_sequencer.sv
// Weight-stationary tile sequencer: walks weight load, skewed iact streaming
// and skewed psum write-back for each tile, with optional K-tile accumulation.
module ws_tile_sequencer #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int PE_LAT  = 17,
    parameter int MEM_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic [CNT_W-1:0]              num_vec,
    input  logic [CNT_W-1:0]              num_tiles,
    input  logic                          accumulate,
    output logic                          busy,
    output logic                          done,
    output logic                          load_weight,
    output logic [ADDR_W-1:0]             weight_addr,
    output logic [COLS-1:0][ADDR_W-1:0]   iact_addr,
    output logic [COLS-1:0]               load_iact,
    output logic [ROWS-1:0][ADDR_W-1:0]   psum_addr,
    output logic [ROWS-1:0]               psum_valid,
    output logic [ROWS-1:0]               psum_acc
);

    // Step counter is wider than CNT_W so an all-ones num_vec plus the
    // pipeline drain still fits.
    localparam int TW = CNT_W + 2;

    localparam logic [TW-1:0]     WL_LAST = TW'(COLS + MEM_LAT - 1);
    localparam logic [TW-1:0]     PIPE    = TW'(MEM_LAT + PE_LAT + ROWS - 1);
    localparam logic [TW-1:0]     MEM_T   = TW'(MEM_LAT);
    localparam logic [TW-1:0]     COLS_T  = TW'(COLS);
    localparam logic [TW-1:0]     ONE_T   = TW'(1);
    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [CNT_W:0]    ONE_C   = (CNT_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WLOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state, nstate;
    logic [TW-1:0]       cnt, ncnt;
    logic [CNT_W-1:0]    tile, ntile;
    logic [CNT_W-1:0]    nv_q, nt_q;
    logic                acc_q;

    logic [TW-1:0]       nv_t;
    logic [TW-1:0]       s_last;
    logic [CNT_W:0]      tile_inc;

    logic                        busy_nxt, done_nxt, lw_nxt;
    logic [ADDR_W-1:0]           wa_nxt, base;
    logic [COLS-1:0][ADDR_W-1:0] ia_nxt;
    logic [COLS-1:0]             li_nxt;
    logic [ROWS-1:0][ADDR_W-1:0] pa_nxt;
    logic [ROWS-1:0]             pv_nxt, pacc_nxt;

    assign nv_t     = TW'(nv_q);
    assign s_last   = PIPE + nv_t - ONE_T;
    assign tile_inc = {1'b0, tile} + ONE_C;

    always_comb begin
        nstate = state;
        ncnt   = cnt;
        ntile  = tile;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    ncnt  = '0;
                    ntile = '0;
                    if (num_vec == '0 || num_tiles == '0)
                        nstate = S_DONE;
                    else
                        nstate = S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (cnt == WL_LAST) begin
                    nstate = S_STREAM;
                    ncnt   = '0;
                end else begin
                    ncnt = cnt + ONE_T;
                end
            end
            S_STREAM: begin
                if (cnt == s_last) begin
                    ncnt = '0;
                    if (tile_inc < {1'b0, nt_q}) begin
                        nstate = S_WLOAD;
                        ntile  = tile_inc[CNT_W-1:0];
                    end else begin
                        nstate = S_DONE;
                    end
                end else begin
                    ncnt = cnt + ONE_T;
                end
            end
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        busy_nxt = (nstate != S_IDLE);
        done_nxt = (nstate == S_DONE);
        lw_nxt   = (nstate == S_WLOAD) && (ncnt >= MEM_T);
        wa_nxt   = weight_addr;
        if (nstate == S_WLOAD && ncnt < COLS_T)
            wa_nxt = ADDR_W'(ntile) * COLS_A + ADDR_W'(ncnt);
        base     = acc_q ? '0 : ADDR_W'(ntile) * ADDR_W'(nv_q);
        ia_nxt   = iact_addr;
        li_nxt   = '0;
        pa_nxt   = psum_addr;
        pv_nxt   = '0;
        pacc_nxt = '0;
        if (nstate == S_STREAM) begin
            for (int c = 0; c < COLS; c++) begin
                if (ncnt >= TW'(c) && ncnt - TW'(c) < nv_t)
                    ia_nxt[c] = ADDR_W'(ncnt - TW'(c));
                if (ncnt >= TW'(MEM_LAT + c) &&
                    ncnt - TW'(MEM_LAT + c) < nv_t)
                    li_nxt[c] = 1'b1;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (ncnt >= TW'(MEM_LAT + PE_LAT + r) &&
                    ncnt - TW'(MEM_LAT + PE_LAT + r) < nv_t) begin
                    pv_nxt[r]   = 1'b1;
                    pa_nxt[r]   = base +
                        ADDR_W'(ncnt - TW'(MEM_LAT + PE_LAT + r));
                    pacc_nxt[r] = acc_q && (ntile != '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tile        <= '0;
            nv_q        <= '0;
            nt_q        <= '0;
            acc_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_weight <= 1'b0;
            weight_addr <= '0;
            iact_addr   <= '0;
            load_iact   <= '0;
            psum_addr   <= '0;
            psum_valid  <= '0;
            psum_acc    <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            tile  <= ntile;
            if (state == S_IDLE && go) begin
                nv_q  <= num_vec;
                nt_q  <= num_tiles;
                acc_q <= accumulate;
            end
            busy        <= busy_nxt;
            done        <= done_nxt;
            load_weight <= lw_nxt;
            weight_addr <= wa_nxt;
            iact_addr   <= ia_nxt;
            load_iact   <= li_nxt;
            psum_addr   <= pa_nxt;
            psum_valid  <= pv_nxt;
            psum_acc    <= pacc_nxt;
        end
    end

endmodule

// File: tb/tb_ws_tile_sequencer.sv
// Directed bench for ws_tile_sequencer on a 4x4 array, PE_LAT=5, MEM_LAT=1.
module tb_ws_tile_sequencer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int AW   = 32;
    localparam int CW   = 16;
    localparam int NCYC = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    go;
    logic [CW-1:0]           num_vec;
    logic [CW-1:0]           num_tiles;
    logic                    accumulate;
    logic                    busy, done, load_weight;
    logic [AW-1:0]           weight_addr;
    logic [COLS-1:0][AW-1:0] iact_addr;
    logic [COLS-1:0]         load_iact;
    logic [ROWS-1:0][AW-1:0] psum_addr;
    logic [ROWS-1:0]         psum_valid;
    logic [ROWS-1:0]         psum_acc;

    int total = 0;
    int bad   = 0;

    logic                    bs_s [NCYC];
    logic                    dn_s [NCYC];
    logic                    lw_s [NCYC];
    logic [AW-1:0]           wa_s [NCYC];
    logic [COLS-1:0][AW-1:0] ia_s [NCYC];
    logic [COLS-1:0]         li_s [NCYC];
    logic [ROWS-1:0][AW-1:0] pa_s [NCYC];
    logic [ROWS-1:0]         pv_s [NCYC];
    logic [ROWS-1:0]         pc_s [NCYC];

    ws_tile_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .ADDR_W(AW), .CNT_W(CW),
        .PE_LAT(5), .MEM_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .num_vec(num_vec), .num_tiles(num_tiles),
        .accumulate(accumulate),
        .busy(busy), .done(done), .load_weight(load_weight),
        .weight_addr(weight_addr), .iact_addr(iact_addr),
        .load_iact(load_iact), .psum_addr(psum_addr),
        .psum_valid(psum_valid), .psum_acc(psum_acc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // go is high in cycle 0 (now); extra go pulses land in cycles ga/gb.
    task automatic run(input int nv, input int nt, input logic acc,
                       input int ncyc, input int ga, input int gb);
        num_vec    = CW'(nv);
        num_tiles  = CW'(nt);
        accumulate = acc;
        go         = 1'b1;
        for (int cy = 1; cy <= ncyc; cy++) begin
            tick();
            go = (cy == ga) || (cy == gb);
            bs_s[cy] = busy;
            dn_s[cy] = done;
            lw_s[cy] = load_weight;
            wa_s[cy] = weight_addr;
            ia_s[cy] = iact_addr;
            li_s[cy] = load_iact;
            pa_s[cy] = psum_addr;
            pv_s[cy] = psum_valid;
            pc_s[cy] = psum_acc;
        end
        go = 1'b0;
    endtask

    task automatic chk_single(input string tg);
        for (int cy = 1; cy <= 22; cy++) begin
            chk($sformatf("%s_lw@%0d", tg, cy), 32'(lw_s[cy]),
                32'(cy >= 2 && cy <= 5));
            if (cy >= 1 && cy <= 4)
                chk($sformatf("%s_wa@%0d", tg, cy), wa_s[cy], 32'(cy - 1));
            if (cy >= 5 && cy <= 17)
                chk($sformatf("%s_wahold@%0d", tg, cy), wa_s[cy], 32'd3);
            for (int c = 0; c < COLS; c++) begin
                chk($sformatf("%s_li%0d@%0d", tg, c, cy), 32'(li_s[cy][c]),
                    32'(cy >= 7 + c && cy <= 9 + c));
                if (cy >= 6 + c && cy <= 8 + c)
                    chk($sformatf("%s_ia%0d@%0d", tg, c, cy), ia_s[cy][c],
                        32'(cy - 6 - c));
            end
            for (int r = 0; r < ROWS; r++) begin
                chk($sformatf("%s_pv%0d@%0d", tg, r, cy), 32'(pv_s[cy][r]),
                    32'(cy >= 12 + r && cy <= 14 + r));
                chk($sformatf("%s_pc%0d@%0d", tg, r, cy), 32'(pc_s[cy][r]),
                    32'd0);
                if (cy >= 12 + r && cy <= 14 + r)
                    chk($sformatf("%s_pa%0d@%0d", tg, r, cy), pa_s[cy][r],
                        32'(cy - 12 - r));
            end
            chk($sformatf("%s_done@%0d", tg, cy), 32'(dn_s[cy]),
                32'(cy == 18));
            chk($sformatf("%s_busy@%0d", tg, cy), 32'(bs_s[cy]),
                32'(cy >= 1 && cy <= 18));
        end
    endtask

    task automatic chk_two(input string tg, input logic acc);
        int t, o;
        for (int cy = 1; cy <= 38; cy++) begin
            t = (cy >= 18) ? 1 : 0;
            o = (cy >= 18) ? 17 : 0;
            chk($sformatf("%s_lw@%0d", tg, cy), 32'(lw_s[cy]),
                32'((cy >= 2 && cy <= 5) || (cy >= 19 && cy <= 22)));
            if (cy >= 1 && cy <= 4)
                chk($sformatf("%s_wa@%0d", tg, cy), wa_s[cy], 32'(cy - 1));
            if (cy >= 18 && cy <= 21)
                chk($sformatf("%s_wa@%0d", tg, cy), wa_s[cy], 32'(cy - 14));
            if (cy >= 22 && cy <= 36)
                chk($sformatf("%s_wahold@%0d", tg, cy), wa_s[cy], 32'd7);
            for (int r = 0; r < ROWS; r++) begin
                if (cy - o >= 12 + r && cy - o <= 14 + r) begin
                    chk($sformatf("%s_pv%0d@%0d", tg, r, cy),
                        32'(pv_s[cy][r]), 32'd1);
                    chk($sformatf("%s_pa%0d@%0d", tg, r, cy), pa_s[cy][r],
                        32'((acc ? 0 : 3 * t) + cy - o - 12 - r));
                    chk($sformatf("%s_pc%0d@%0d", tg, r, cy),
                        32'(pc_s[cy][r]), 32'(acc && t == 1));
                end else begin
                    chk($sformatf("%s_pv%0d@%0d", tg, r, cy),
                        32'(pv_s[cy][r]), 32'd0);
                end
            end
            chk($sformatf("%s_done@%0d", tg, cy), 32'(dn_s[cy]),
                32'(cy == 35));
            chk($sformatf("%s_busy@%0d", tg, cy), 32'(bs_s[cy]),
                32'(cy >= 1 && cy <= 35));
        end
    endtask

    task automatic chk_degen(input string tg);
        for (int cy = 1; cy <= 6; cy++) begin
            chk($sformatf("%s_done@%0d", tg, cy), 32'(dn_s[cy]),
                32'(cy == 1));
            chk($sformatf("%s_busy@%0d", tg, cy), 32'(bs_s[cy]),
                32'(cy == 1));
            chk($sformatf("%s_lw@%0d", tg, cy), 32'(lw_s[cy]), 32'd0);
            chk($sformatf("%s_li@%0d", tg, cy), 32'(li_s[cy]), 32'd0);
            chk($sformatf("%s_pv@%0d", tg, cy), 32'(pv_s[cy]), 32'd0);
        end
    endtask

    task automatic chk_zero(input string tg);
        chk({tg, "_busy"}, 32'(busy), 32'd0);
        chk({tg, "_done"}, 32'(done), 32'd0);
        chk({tg, "_lw"}, 32'(load_weight), 32'd0);
        chk({tg, "_wa"}, weight_addr, 32'd0);
        chk({tg, "_li"}, 32'(load_iact), 32'd0);
        chk({tg, "_pv"}, 32'(psum_valid), 32'd0);
        chk({tg, "_pc"}, 32'(psum_acc), 32'd0);
        for (int c = 0; c < COLS; c++)
            chk($sformatf("%s_ia%0d", tg, c), iact_addr[c], 32'd0);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("%s_pa%0d", tg, r), psum_addr[r], 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        go         = 1'b1;
        num_vec    = 16'd3;
        num_tiles  = 16'd1;
        accumulate = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        go  = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);

        run(3, 1, 1'b0, 22, -1, -1);
        chk_single("single");

        run(3, 2, 1'b0, 38, -1, -1);
        chk_two("two", 1'b0);

        run(3, 2, 1'b1, 38, -1, -1);
        chk_two("two_acc", 1'b1);

        run(0, 1, 1'b0, 6, -1, -1);
        chk_degen("nv0");

        run(3, 0, 1'b0, 6, -1, -1);
        chk_degen("nt0");

        run(3, 1, 1'b0, 22, 3, 10);
        chk_single("ign_go");

        // Reset in cycle 9 of a run, then a fresh go in cycle 12.
        num_vec    = 16'd3;
        num_tiles  = 16'd1;
        accumulate = 1'b0;
        go         = 1'b1;
        for (int cy = 1; cy <= 9; cy++) begin
            tick();
            go = 1'b0;
        end
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("abort");
        tick();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_done", 32'(done), 32'd0);
        tick();
        run(3, 1, 1'b0, 22, -1, -1);
        chk_single("replay");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
